// File: rtl/axis_testpattern_checker.sv
// AXI4-Stream sink that locks onto the counter test-pattern sequence and reports
// lock state, mismatches, beat/wrap counts and the first failing data pair.
module axis_testpattern_checker #(
  parameter int S00_AXIS_TDATA_WIDTH = 32,
  parameter int COUNTER_START        = 1,
  parameter int COUNTER_END          = 5,
  parameter int COUNTER_INCR         = 1,
  parameter int READY_PERIOD         = 1,
  parameter int LOSS_THRESH          = 4,
  parameter int CNT_WIDTH            = 16
) (
  input  logic                            s_axis_aclk,
  input  logic                            s_axis_aresetn,
  input  logic [S00_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            clear,
  output logic                            locked,
  output logic                            error,
  output logic [CNT_WIDTH-1:0]            error_count,
  output logic [CNT_WIDTH-1:0]            beat_count,
  output logic [CNT_WIDTH-1:0]            wrap_count,
  output logic [S00_AXIS_TDATA_WIDTH-1:0] first_bad_data,
  output logic [S00_AXIS_TDATA_WIDTH-1:0] first_bad_expected
);

  localparam int W        = S00_AXIS_TDATA_WIDTH;
  localparam int TC_W     = (READY_PERIOD > 1) ? $clog2(READY_PERIOD) : 1;
  localparam int CONSEC_W = $clog2(LOSS_THRESH + 1);

  localparam logic [TC_W-1:0]      TC_LAST     = TC_W'(READY_PERIOD - 1);
  localparam logic [TC_W-1:0]      TC_ONE      = TC_W'(1);
  localparam logic [CONSEC_W-1:0]  CONSEC_LAST = CONSEC_W'(LOSS_THRESH);
  localparam logic [CONSEC_W-1:0]  CONSEC_ONE  = CONSEC_W'(1);
  localparam logic [W-1:0]         START_V     = W'(COUNTER_START);
  localparam logic [W-1:0]         END_V       = W'(COUNTER_END);
  localparam logic [W-1:0]         INCR_V      = W'(COUNTER_INCR);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX     = {CNT_WIDTH{1'b1}};

  typedef enum logic [0:0] {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  function automatic logic [W-1:0] next_val(input logic [W-1:0] v);
    logic [W-1:0] n;
    if (v >= END_V) begin
      n = START_V;
    end else begin
      n = v + INCR_V;
    end
    return n;
  endfunction

  logic [TC_W-1:0]      r_tc;
  logic                 r_tready;
  state_t               r_state;
  logic [W-1:0]         r_expected;
  logic [CONSEC_W-1:0]  r_consec;
  logic                 r_locked;
  logic                 r_error;
  logic [CNT_WIDTH-1:0] r_err_cnt;
  logic [CNT_WIDTH-1:0] r_beat_cnt;
  logic [CNT_WIDTH-1:0] r_wrap_cnt;
  logic                 r_first_seen;
  logic [W-1:0]         r_fbd;
  logic [W-1:0]         r_fbe;

  state_t               w_state_nxt;
  logic [W-1:0]         w_expected_nxt;
  logic [CONSEC_W-1:0]  w_consec_nxt;
  logic [CONSEC_W-1:0]  w_consec_inc;
  logic                 w_error_nxt;
  logic [CNT_WIDTH-1:0] w_err_cnt_nxt;
  logic [CNT_WIDTH-1:0] w_beat_cnt_nxt;
  logic [CNT_WIDTH-1:0] w_wrap_cnt_nxt;
  logic                 w_first_seen_nxt;
  logic [W-1:0]         w_fbd_nxt;
  logic [W-1:0]         w_fbe_nxt;
  logic                 w_accept;
  logic                 w_match;

  assign w_accept     = s_axis_tvalid & r_tready;
  assign w_match      = (s_axis_tdata == r_expected);
  assign w_consec_inc = r_consec + CONSEC_ONE;

  // Deterministic backpressure: one ready cycle per READY_PERIOD, independent of tvalid.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      r_tc     <= {TC_W{1'b0}};
      r_tready <= 1'b0;
    end else begin
      r_tready <= (r_tc == TC_LAST);
      r_tc     <= (r_tc == TC_LAST) ? {TC_W{1'b0}} : (r_tc + TC_ONE);
    end
  end

  // Next-state and status update; clear outranks any beat in the same cycle.
  always_comb begin
    w_state_nxt      = r_state;
    w_expected_nxt   = r_expected;
    w_consec_nxt     = r_consec;
    w_error_nxt      = 1'b0;
    w_err_cnt_nxt    = r_err_cnt;
    w_beat_cnt_nxt   = r_beat_cnt;
    w_wrap_cnt_nxt   = r_wrap_cnt;
    w_first_seen_nxt = r_first_seen;
    w_fbd_nxt        = r_fbd;
    w_fbe_nxt        = r_fbe;
    if (clear) begin
      w_state_nxt      = ST_HUNT;
      w_expected_nxt   = {W{1'b0}};
      w_consec_nxt     = {CONSEC_W{1'b0}};
      w_err_cnt_nxt    = {CNT_WIDTH{1'b0}};
      w_beat_cnt_nxt   = {CNT_WIDTH{1'b0}};
      w_wrap_cnt_nxt   = {CNT_WIDTH{1'b0}};
      w_first_seen_nxt = 1'b0;
      w_fbd_nxt        = {W{1'b0}};
      w_fbe_nxt        = {W{1'b0}};
    end else if (w_accept) begin
      w_beat_cnt_nxt = r_beat_cnt + CNT_ONE;
      case (r_state)
        ST_HUNT: begin
          w_expected_nxt = next_val(s_axis_tdata);
          w_consec_nxt   = {CONSEC_W{1'b0}};
          w_state_nxt    = ST_LOCKED;
        end
        ST_LOCKED: begin
          if (w_match) begin
            w_consec_nxt   = {CONSEC_W{1'b0}};
            w_expected_nxt = next_val(s_axis_tdata);
            if (s_axis_tdata >= END_V) begin
              w_wrap_cnt_nxt = r_wrap_cnt + CNT_ONE;
            end else begin
              w_wrap_cnt_nxt = r_wrap_cnt;
            end
          end else begin
            w_error_nxt    = 1'b1;
            w_err_cnt_nxt  = (r_err_cnt == CNT_MAX) ? r_err_cnt : (r_err_cnt + CNT_ONE);
            // Advance past the bad beat so one corrupt word costs exactly one error.
            w_expected_nxt = next_val(r_expected);
            if (!r_first_seen) begin
              w_first_seen_nxt = 1'b1;
              w_fbd_nxt        = s_axis_tdata;
              w_fbe_nxt        = r_expected;
            end else begin
              w_first_seen_nxt = r_first_seen;
            end
            if (w_consec_inc == CONSEC_LAST) begin
              w_state_nxt  = ST_HUNT;
              w_consec_nxt = {CONSEC_W{1'b0}};
            end else begin
              w_consec_nxt = w_consec_inc;
            end
          end
        end
        default: begin
          w_state_nxt = ST_HUNT;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // State and status registers.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      r_state      <= ST_HUNT;
      r_expected   <= {W{1'b0}};
      r_consec     <= {CONSEC_W{1'b0}};
      r_locked     <= 1'b0;
      r_error      <= 1'b0;
      r_err_cnt    <= {CNT_WIDTH{1'b0}};
      r_beat_cnt   <= {CNT_WIDTH{1'b0}};
      r_wrap_cnt   <= {CNT_WIDTH{1'b0}};
      r_first_seen <= 1'b0;
      r_fbd        <= {W{1'b0}};
      r_fbe        <= {W{1'b0}};
    end else begin
      r_state      <= w_state_nxt;
      r_expected   <= w_expected_nxt;
      r_consec     <= w_consec_nxt;
      r_locked     <= (w_state_nxt == ST_LOCKED);
      r_error      <= w_error_nxt;
      r_err_cnt    <= w_err_cnt_nxt;
      r_beat_cnt   <= w_beat_cnt_nxt;
      r_wrap_cnt   <= w_wrap_cnt_nxt;
      r_first_seen <= w_first_seen_nxt;
      r_fbd        <= w_fbd_nxt;
      r_fbe        <= w_fbe_nxt;
    end
  end

  assign s_axis_tready      = r_tready;
  assign locked             = r_locked;
  assign error              = r_error;
  assign error_count        = r_err_cnt;
  assign beat_count         = r_beat_cnt;
  assign wrap_count         = r_wrap_cnt;
  assign first_bad_data     = r_fbd;
  assign first_bad_expected = r_fbe;

endmodule
